// File: rtl/ram_bist_if.sv
// Single-port SRAM bank port as seen by the BIST initiator: registered request side
// plus one-cycle-latency read data.
interface ram_bist_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                      mem_en_o;
  logic [ADDR_WIDTH-1:0]     mem_addr_o;
  logic                      mem_we_o;
  logic [DATA_WIDTH/8-1:0]   mem_be_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;

  modport master (
    output mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/ram_bist.sv
// March C- BIST controller: drives the SRAM port one op per cycle through M0..M5,
// compares read data one cycle later and records pass/fail, first failure and error count.
module ram_bist #(
  parameter int                    ADDR_WIDTH = 15,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 8192,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 32'h5555_5555
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  ram_bist_if.master            mem
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int WW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WW-1:0]         W_LAST = WW'(NUM_WORDS - 1);
  localparam logic [WW-1:0]         W_ZERO = WW'(0);
  localparam logic [WW-1:0]         W_ONE  = WW'(1);
  localparam logic [DATA_WIDTH-1:0] BG0    = PATTERN;
  localparam logic [DATA_WIDTH-1:0] BG1    = ~PATTERN;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_M0    = 4'd1,
    S_M1    = 4'd2,
    S_M2    = 4'd3,
    S_M3    = 4'd4,
    S_M4    = 4'd5,
    S_M5    = 4'd6,
    S_DRAIN = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t          state, nxt_state;
  logic [WW-1:0]   w_idx, nxt_w;
  logic            phase, nxt_phase;   // 0: read half of an r/w pair, 1: write half
  logic            accept;
  logic            nxt_en, nxt_we;
  logic [DATA_WIDTH-1:0] wr_val, rd_val;

  logic                  op_is_rd;
  logic [DATA_WIDTH-1:0] op_exp;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] pend_exp;
  logic [ADDR_WIDTH-1:0] pend_addr;

  // Next memory op: element, word index and r/w phase to present after this edge.
  always_comb begin
    nxt_state = state;
    nxt_w     = w_idx;
    nxt_phase = phase;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          accept    = 1'b1;
          nxt_state = S_M0;
          nxt_w     = W_ZERO;
          nxt_phase = 1'b1;
        end else begin
          accept    = 1'b0;
        end
      end
      S_M0: begin
        if (w_idx == W_LAST) begin
          nxt_state = S_M1;
          nxt_w     = W_ZERO;
          nxt_phase = 1'b0;
        end else begin
          nxt_w     = w_idx + W_ONE;
        end
      end
      S_M1, S_M2: begin
        if (!phase) begin
          nxt_phase = 1'b1;
        end else if (w_idx != W_LAST) begin
          nxt_w     = w_idx + W_ONE;
          nxt_phase = 1'b0;
        end else if (state == S_M1) begin
          nxt_state = S_M2;
          nxt_w     = W_ZERO;
          nxt_phase = 1'b0;
        end else begin
          nxt_state = S_M3;
          nxt_w     = W_LAST;
          nxt_phase = 1'b0;
        end
      end
      S_M3, S_M4: begin
        if (!phase) begin
          nxt_phase = 1'b1;
        end else if (w_idx != W_ZERO) begin
          nxt_w     = w_idx - W_ONE;
          nxt_phase = 1'b0;
        end else if (state == S_M3) begin
          nxt_state = S_M4;
          nxt_w     = W_LAST;
          nxt_phase = 1'b0;
        end else begin
          nxt_state = S_M5;
          nxt_w     = W_ZERO;
          nxt_phase = 1'b0;
        end
      end
      S_M5: begin
        if (w_idx == W_LAST) begin
          nxt_state = S_DRAIN;
        end else begin
          nxt_w     = w_idx + W_ONE;
        end
      end
      S_DRAIN: nxt_state = S_DONE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Decode the next op into enable, direction, write value and expected read value.
  always_comb begin
    nxt_en = 1'b0;
    nxt_we = 1'b0;
    wr_val = {DATA_WIDTH{1'b0}};
    rd_val = {DATA_WIDTH{1'b0}};
    case (nxt_state)
      S_M0: begin nxt_en = 1'b1; nxt_we = 1'b1;      wr_val = BG0; end
      S_M1: begin nxt_en = 1'b1; nxt_we = nxt_phase; wr_val = BG1; rd_val = BG0; end
      S_M2: begin nxt_en = 1'b1; nxt_we = nxt_phase; wr_val = BG0; rd_val = BG1; end
      S_M3: begin nxt_en = 1'b1; nxt_we = nxt_phase; wr_val = BG1; rd_val = BG0; end
      S_M4: begin nxt_en = 1'b1; nxt_we = nxt_phase; wr_val = BG0; rd_val = BG1; end
      S_M5: begin nxt_en = 1'b1; nxt_we = 1'b0;      rd_val = BG0; end
      default: begin nxt_en = 1'b0; nxt_we = 1'b0; end
    endcase
  end

  // FSM, registered memory port, compare pipeline and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      w_idx           <= W_ZERO;
      phase           <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      fail_o          <= 1'b0;
      err_cnt_o       <= 16'h0000;
      fail_addr_o     <= {ADDR_WIDTH{1'b0}};
      fail_data_o     <= {DATA_WIDTH{1'b0}};
      mem.mem_en_o    <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_be_o    <= {BYTES{1'b0}};
      mem.mem_addr_o  <= {ADDR_WIDTH{1'b0}};
      mem.mem_wdata_o <= {DATA_WIDTH{1'b0}};
      op_is_rd        <= 1'b0;
      op_exp          <= {DATA_WIDTH{1'b0}};
      rd_pend         <= 1'b0;
      pend_exp        <= {DATA_WIDTH{1'b0}};
      pend_addr       <= {ADDR_WIDTH{1'b0}};
    end else begin
      state           <= nxt_state;
      w_idx           <= nxt_w;
      phase           <= nxt_phase;
      busy_o          <= nxt_en | (nxt_state == S_DRAIN);
      done_o          <= (nxt_state == S_DONE);
      mem.mem_en_o    <= nxt_en;
      mem.mem_we_o    <= nxt_we;
      mem.mem_be_o    <= nxt_we ? {BYTES{1'b1}} : {BYTES{1'b0}};
      mem.mem_addr_o  <= nxt_en ? (ADDR_WIDTH'(nxt_w) << BSH) : {ADDR_WIDTH{1'b0}};
      mem.mem_wdata_o <= nxt_we ? wr_val : {DATA_WIDTH{1'b0}};
      op_is_rd        <= nxt_en & ~nxt_we;
      op_exp          <= rd_val;
      // Read data arrives the cycle after the read is presented, so expectation lags one stage.
      rd_pend         <= op_is_rd;
      pend_exp        <= op_exp;
      pend_addr       <= mem.mem_addr_o;
      if (accept) begin
        fail_o      <= 1'b0;
        err_cnt_o   <= 16'h0000;
        fail_addr_o <= {ADDR_WIDTH{1'b0}};
        fail_data_o <= {DATA_WIDTH{1'b0}};
      end else if (rd_pend && (mem.mem_rdata_i != pend_exp)) begin
        fail_o <= 1'b1;
        if (err_cnt_o != 16'hFFFF) begin
          err_cnt_o <= err_cnt_o + 16'h0001;
        end else begin
          err_cnt_o <= err_cnt_o;
        end
        if (!fail_o) begin
          fail_addr_o <= pend_addr;
          fail_data_o <= mem.mem_rdata_i;
        end else begin
          fail_addr_o <= fail_addr_o;
        end
      end else begin
        fail_o <= fail_o;
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with N=16 against a behavioural SRAM that can inject
// single stuck-at faults on reads.
module tb_ram_bist;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, fail;
  logic [15:0] err_cnt;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram ();

  ram_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(N), .PATTERN(32'h5555_5555)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .fail_o(fail), .err_cnt_o(err_cnt), .fail_addr_o(fail_addr), .fail_data_o(fail_data),
    .mem(ram.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fault_mode = 0;   // 0 none, 1 word5 bit3 stuck-1, 2 word15 bit0 stuck-0
  logic [DW-1:0] arr [0:N-1];

  function automatic logic [DW-1:0] faulty(input int idx, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (fault_mode == 1 && idx == 5) r[3] = 1'b1;
    if (fault_mode == 2 && idx == 15) r[0] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram.mem_en_o) begin
      if (ram.mem_we_o) arr[ram.mem_addr_o[5:2]] <= ram.mem_wdata_o;
      else ram.mem_rdata_i <= faulty(int'(ram.mem_addr_o[5:2]), arr[ram.mem_addr_o[5:2]]);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // per-cycle op log of the latest run
  logic [AW-1:0] log_addr [1:400];
  logic          log_we   [1:400];
  logic [3:0]    log_be   [1:400];
  logic [DW-1:0] log_wd   [1:400];
  int done_cyc, en_cnt;

  // Pulse start, follow the run until done or a cycle budget; optionally poke start while busy
  // or pull reset at cycle rst_at (0 = never).
  task automatic run(input bit poke, input int rst_at);
    int c;
    done_cyc = 0;
    en_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 1;
    while (c <= 400 && done_cyc == 0) begin
      if (poke) start = (c == 50 || c == 100 || c == 161);
      if (rst_at != 0 && c == rst_at) begin
        check("en_before_reset", {63'd0, ram.mem_en_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("busy_in_reset", {63'd0, busy}, 64'd0);
        check("en_in_reset", {63'd0, ram.mem_en_o}, 64'd0);
        check("addr_we_be_in_reset", {44'd0, ram.mem_addr_o, ram.mem_we_o, ram.mem_be_o}, 64'd0);
        return;
      end
      if (ram.mem_en_o) begin
        en_cnt++;
        log_addr[c] = ram.mem_addr_o;
        log_we[c]   = ram.mem_we_o;
        log_be[c]   = ram.mem_be_o;
        log_wd[c]   = ram.mem_wdata_o;
      end
      if (done) done_cyc = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    check("done_cycle", 64'(done_cyc), 64'd162);
    check("en_cycles", 64'(en_cnt), 64'd160);
    check("busy_at_done", {62'd0, busy, ram.mem_en_o}, 64'd0);
  endtask

  // Expected op at cycle c of a run, derived from the March C- element list.
  task automatic exp_op(input int c, output int a, output bit we, output logic [DW-1:0] wd);
    int k;
    if (c <= 16) begin
      a = (c - 1) * 4; we = 1'b1; wd = 32'h5555_5555;
    end else if (c <= 80) begin
      k = c - 17; a = ((k % 32) / 2) * 4; we = (k % 2) == 1;
      wd = (c <= 48) ? 32'hAAAA_AAAA : 32'h5555_5555;
    end else if (c <= 144) begin
      k = c - 81; a = (15 - (k % 32) / 2) * 4; we = (k % 2) == 1;
      wd = (c <= 112) ? 32'hAAAA_AAAA : 32'h5555_5555;
    end else begin
      a = (c - 145) * 4; we = 1'b0; wd = 32'h0;
    end
  endtask

  initial begin
    int a, nbad, m3first, m4last;
    bit we;
    logic [DW-1:0] wd;

    #12;
    check("rst_status", {60'd0, busy, done, fail, ram.mem_en_o}, 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_fail_addr_data", {17'd0, fail_addr, fail_data}, 64'd0);
    check("rst_mem_port", {12'd0, ram.mem_addr_o, ram.mem_we_o, ram.mem_be_o}, 64'd0);
    check("rst_wdata", 64'(ram.mem_wdata_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // fault-free run with op-order logging
    fault_mode = 0;
    run(1'b0, 0);
    check("clean_fail", {63'd0, fail}, 64'd0);
    check("clean_err", 64'(err_cnt), 64'd0);
    nbad = 0;
    for (int c = 1; c <= 160; c++) begin
      exp_op(c, a, we, wd);
      if (log_addr[c] !== AW'(a) || log_we[c] !== we || log_be[c] !== (we ? 4'hF : 4'h0)
          || (we && log_wd[c] !== wd)) nbad++;
    end
    check("op_sequence_errs", 64'(nbad), 64'd0);
    m3first = int'(log_addr[81]);
    m4last  = int'(log_addr[144]);
    check("m3_first_addr", 64'(m3first), 64'h3C);
    check("m4_last_addr", 64'(m4last), 64'h00);

    // stuck-at-1 bit 3 of word 5
    fault_mode = 1;
    run(1'b0, 0);
    check("sa1_fail", {63'd0, fail}, 64'd1);
    check("sa1_err", 64'(err_cnt), 64'd3);
    check("sa1_addr", 64'(fail_addr), 64'h14);
    check("sa1_data", 64'(fail_data), 64'h5555_555D);

    // stuck-at-0 bit 0 of last word
    fault_mode = 2;
    run(1'b0, 0);
    check("sa0_fail", {63'd0, fail}, 64'd1);
    check("sa0_err", 64'(err_cnt), 64'd3);
    check("sa0_addr", 64'(fail_addr), 64'h3C);
    check("sa0_data", 64'(fail_data), 64'h5555_5554);

    // clean run from a failed DONE clears results
    fault_mode = 0;
    run(1'b0, 0);
    check("clear_fail", {63'd0, fail}, 64'd0);
    check("clear_err_addr", {32'd0, err_cnt, 1'b0, fail_addr}, 64'd0);

    // reset during M2, then rerun with start pokes while busy
    fault_mode = 1;
    run(1'b0, 60);
    check("midrst_results", {16'd0, done, fail, err_cnt[13:0], fail_data}, 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    fault_mode = 0;
    run(1'b1, 0);
    check("rerun_fail", {63'd0, fail}, 64'd0);
    check("rerun_err", 64'(err_cnt), 64'd0);
    repeat (3) @(negedge clk);
    check("rerun_done_holds", {62'd0, done, busy}, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
